// File: rtl/dmem_responder.sv
// Wait-stated data RAM responder for the CPU data-memory port.
// Accepts one load/store at a time over valid/ready and answers over a response channel.
// Access sizes follow RISC-V funct3: B, H, W and the zero-extending BU, HU.
// The lane logic assumes a 32-bit WIDTH.
module dmem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_addrmode,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             write_q;
  logic [2:0]       mode_q;
  logic [AW+1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             run_q;

  logic             accept, access, req_bad;
  logic             mode_bad, misalign, range_bad;
  logic             acc_write;
  logic [2:0]       acc_mode;
  logic [AW+1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic [WIDTH-1:0] rd_word, load_val, wr_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [3:0]       wr_be;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid & req_ready;

  // Decode a rejected request from the live request fields at accept time.
  always_comb begin
    mode_bad = 1'b0;
    misalign = 1'b0;
    case (req_addrmode)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = req_addr[0];
      3'b010:         misalign = |req_addr[1:0];
      default:        mode_bad = 1'b1;
    endcase
    // Unsigned modes only make sense for loads.
    if (req_write && req_addrmode[2]) mode_bad = 1'b1;
    range_bad = {2'b00, req_addr[WIDTH-1:2]} >= WIDTH'(DEPTH_WORDS);
    req_bad   = mode_bad | misalign | range_bad;
  end

  // With no wait states the access uses the live request on the accept edge.
  always_comb begin
    if (state_q == StIdle) begin
      acc_write = req_write;
      acc_mode  = req_addrmode;
      acc_addr  = req_addr[AW+1:0];
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_mode  = mode_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // Lane selection and extension for loads, byte enables and lane replication for stores.
  always_comb begin
    rd_word  = mem[acc_addr[AW+1:2]];
    byte_v   = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    half_v   = rd_word[{acc_addr[1], 4'b0000} +: 16];
    load_val = rd_word;
    wr_be    = 4'b1111;
    wr_word  = acc_wdata;
    case (acc_mode)
      3'b000: load_val = {{(WIDTH-8){byte_v[7]}}, byte_v};
      3'b100: load_val = {{(WIDTH-8){1'b0}}, byte_v};
      3'b001: load_val = {{(WIDTH-16){half_v[15]}}, half_v};
      3'b101: load_val = {{(WIDTH-16){1'b0}}, half_v};
      default: load_val = rd_word;
    endcase
    case (acc_mode[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << acc_addr[1:0];
        wr_word = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{acc_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_word = acc_wdata;
      end
    endcase
  end

  // Next-state, wait counter and response register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_bad) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (access) begin
      err_d   = 1'b0;
      rdata_d = acc_write ? '0 : load_val;
    end
  end

  // Control and response state with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      run_q   <= 1'b1;
    end
  end

  // Request fields captured on accept; later request changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_q <= 1'b0;
      mode_q  <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      mode_q  <= req_addrmode;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  // RAM write on the edge entering the response state. run_q is cleared by reset so an
  // accept seen while reset is held (possible with no wait states) never writes.
  always_ff @(posedge clk) begin
    if (access && acc_write && run_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[acc_addr[AW+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with two wait states
// and a second with none, sharing the request and response-ready inputs.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_addrmode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        req_ready0, resp_valid0, resp_err0;
  logic [31:0] resp_rdata0;

  int errors = 0;
  int checks = 0;

  localparam int unsigned W = 2;

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addrmode(req_addrmode), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_write(req_write), .req_addrmode(req_addrmode), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request to the two-wait-state instance; lat counts edges after the accept
  // edge until resp_valid is seen (0 means visible right after the accept edge).
  task automatic xact(input logic w, input logic [2:0] mode, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                      output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addrmode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addrmode = 3'b111;
    req_addr = ~addr; req_wdata = ~wdata;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    if (resp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid);
    end
    checks++;
    if (resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata);
    end
    checks++;
    if (resp_err !== 1'b0) begin
      errors++; $display("FAIL reset_resp_err got %b want 0", resp_err);
    end
    checks++;
    if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      errors++; $display("FAIL reset_dut0 got valid=%b ready=%b want 0/1", resp_valid0, req_ready0);
    end
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, rd, er);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL sw_latency got %0d want %0d", lat, W); end
    checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", er, rd);
    end
    xact(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL lw_latency got %0d want %0d", lat, W); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_data got %h err=%b want deadbeef err=0", rd, er);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic er;
    logic [2:0]  modes [5] = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001};
    logic [31:0] addrs [5] = '{32'h10, 32'h12, 32'h12, 32'h12, 32'h10};
    logic [31:0] exps  [5] = '{32'hDE80BEEF, 32'hFFFFFF80, 32'h00000080,
                               32'h0000DE80, 32'hFFFFBEEF};
    xact(1'b1, 3'b000, 32'h12, 32'hFFFFFF80, lat, rd, er);
    checks++;
    if (er !== 1'b0 || lat !== W) begin
      errors++; $display("FAIL sb_resp got err=%b lat=%0d want 0/%0d", er, lat, W);
    end
    for (int i = 0; i < 5; i++) begin
      xact(1'b0, modes[i], addrs[i], 32'h0, lat, rd, er);
      checks++;
      if (rd !== exps[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL lane_load%0d got %h err=%b want %h err=0", i, rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    logic        wr_v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  md_v [5] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b010};
    logic [31:0] ad_v [5] = '{32'h11, 32'h0, 32'h1000, 32'h10, 32'h12};
    for (int i = 0; i < 5; i++) begin
      xact(wr_v[i], md_v[i], ad_v[i], 32'h5555AAAA, lat, rd, er);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 0) begin
        errors++;
        $display("FAIL err_case%0d got err=%b rdata=%h lat=%0d want 1/0/0", i, er, rd, lat);
      end
    end
    xact(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'hDE80BEEF || er !== 1'b0) begin
      errors++; $display("FAIL lw_after_err got %h err=%b want de80beef err=0", rd, er);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    resp_ready = 1'b0;
    xact(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'hDE80BEEF || lat !== W) begin
      errors++; $display("FAIL bp_first got %h lat=%0d want de80beef lat=%0d", rd, lat, W);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDE80BEEF || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h e=%b rdy=%b want 1/de80beef/0/0",
                 i, resp_valid, resp_rdata, resp_err, req_ready);
      end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b d=%h want 0/1/0", resp_valid, req_ready,
               resp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_single got v=%b want 0", resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    xact(1'b1, 3'b010, 32'h20, 32'h0, lat, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addrmode = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
    begin
      errors++;
      $display("FAIL mid_reset got rdy=%b v=%b d=%h e=%b want 1/0/0/0", req_ready, resp_valid,
               resp_rdata, resp_err);
    end
    @(negedge clk); rst = 1'b1;
    xact(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++; $display("FAIL mid_reset_nowrite got %h err=%b want 0 err=0", rd, er);
    end
  endtask

  task automatic test_wait0();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addrmode = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid0 !== 1'b1 || resp_err0 !== 1'b0 || resp_rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL w0_sw got v=%b e=%b d=%h want 1/0/0", resp_valid0, resp_err0, resp_rdata0);
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addrmode = 3'b010; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (resp_valid0 !== 1'b1 || resp_rdata0 !== 32'hCAFEF00D || resp_err0 !== 1'b0) begin
      errors++;
      $display("FAIL w0_lw got v=%b d=%h e=%b want 1/cafef00d/0", resp_valid0, resp_rdata0,
               resp_err0);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      errors++; $display("FAIL w0_done got v=%b rdy=%b want 0/1", resp_valid0, req_ready0);
    end
    repeat (6) @(posedge clk);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addrmode = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    #12;
    test_reset();
    @(negedge clk); rst = 1'b1;
    test_sw_lw();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_wait0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
